deck_shuffler: RTL and testbench
================================

Name: deck_shuffler

Overview:
- Produces a uniformly shuffled 52-card deck using an LFSR-driven Fisher-Yates shuffle.
- Sits directly upstream of the setup block: setup consumes the packed deck and deals it into the tableaus and the stock/talon piles.
- Card format matches the rest of the design: 7 bits = rank[6:3] (0 = ace … 12 = king), suit[2:1] (00 H, 01 C, 10 D, 11 S), visible[0].
- Every output card has visible = 0; setup sets visibility when it deals.

Parameters:
- DEFAULT_SEED, 16'hACE1: LFSR reset value; also substituted for any zero seed.
- CARD_W, 7: bits per card.
- NUM_CARDS, 52: deck size. Fixed; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- seed  in  16  LFSR seed value
- seed_load  in  1  loads seed into LFSR (IDLE/DONE only)
- start  in  1  single-cycle pulse; begins a new shuffle (IDLE/DONE only)
- busy  out  1  high during INIT and SHUFFLE
- ready  out  1  high in DONE; deck is valid and stable
- deck  out  NUM_CARDS*CARD_W  slot k occupies bits [7k+6:7k]; slot 0 is the top of the deck

Behaviour:
- Reset (rst = 0, async): state = IDLE, deck = all zeros, lfsr = DEFAULT_SEED, index i = 0, busy = 0, ready = 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Shifts right. If the shifted-out bit is 1, XOR the mask into the result.
  - Advances exactly once per cycle in SHUFFLE only. Holds in all other states.
- seed_load in IDLE/DONE: lfsr <= (seed == 0) ? DEFAULT_SEED : seed. Ignored in INIT/SHUFFLE.
- start in IDLE/DONE: go to INIT; ready drops the next cycle.
  - If seed_load and start are asserted in the same cycle, both take effect; the shuffle uses the new seed.
  - start in INIT/SHUFFLE is ignored.
- INIT (1 cycle): slot k <= {rank = k mod 13, suit = k / 13, vis = 0}, for k = 0..51. Set i = 51. Go to SHUFFLE.
- SHUFFLE (one candidate per cycle):
  - lfsr_n = next LFSR value.
  - mask = smallest 2^m - 1 that is >= i (i = 32..51 → 63; 16..31 → 31; 8..15 → 15; 4..7 → 7; 2..3 → 3; 1 → 1).
  - j = lfsr_n[5:0] & mask.
  - If j <= i (accept): swap slot i and slot j in the same cycle (j == i leaves the deck unchanged). Then, if i == 1, go to DONE; otherwise i <= i - 1.
  - If j > i (reject): no deck change; i holds; retry next cycle.
- DONE: ready = 1, busy = 0, deck held stable until the next start or reset.
- Latency: 1 INIT cycle + (51 + rejections) SHUFFLE cycles. Fully deterministic for a given seed.
- Reset asserted mid-operation: immediate return to the reset state. The partial deck is discarded (zeroed).
- Invariant: the deck is always a permutation of the 52 distinct cards (outside reset), and all visible bits are 0.
- Consumer contract: setup samples deck only while ready = 1. The top-level gates setup with deck_shuffler.ready.

Test Plan:
- Reset, then start with no seed_load (seed = ACE1) -> busy = 1 the cycle after start; ready rises after 1 + 51 + rejections cycles; a bench model running the same LFSR/mask/swap algorithm matches deck bit-for-bit.
- After ready -> each of the 52 {rank, suit} codes appears exactly once; every bit [7k] = 0; no rank field > 12.
- seed_load with seed = 0, then start -> result identical to the shuffle from DEFAULT_SEED 16'hACE1. seed = 16'h1234 gives a different deck, and repeating seed = 16'h1234 reproduces it exactly.
- Pulse start, and seed_load with 16'h5555, 10 cycles into SHUFFLE -> both ignored; final deck equals the uninterrupted run; a subsequent start from DONE reshuffles starting from the current LFSR state.
- Assert rst low 20 cycles into SHUFFLE -> deck = 0, busy = 0, ready = 0 asynchronously; after release, lfsr = ACE1 and a new start reproduces the first scenario's deck.
- seed_load (seed = 16'h00FF) and start in the same cycle from IDLE -> shuffle matches the model seeded with 16'h00FF.

Source files
------------

// File: rtl/deck_shuffler.sv
// Fisher-Yates shuffle of a 52-card deck driven by a 16-bit Galois LFSR.
// One swap candidate per cycle; rejected candidates retry with the next LFSR value.
module deck_shuffler #(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter int          CARD_W       = 7,
    parameter int          NUM_CARDS    = 52
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   seed,
    input  logic                          seed_load,
    input  logic                          start,
    output logic                          busy,
    output logic                          ready,
    output logic [NUM_CARDS*CARD_W-1:0]   deck
);

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_INIT    = 2'd1;
    localparam logic [1:0] ST_SHUFFLE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]                             r_state;
    logic [15:0]                            r_lfsr;
    logic [5:0]                             r_idx;
    logic [NUM_CARDS-1:0][CARD_W-1:0]       r_deck;

    logic [NUM_CARDS-1:0][CARD_W-1:0]       w_deck_next;
    logic [15:0]                            w_lfsr_n;
    logic [5:0]                             w_mask;
    logic [5:0]                             w_j;
    logic                                   w_accept;
    logic                                   w_swap;
    logic                                   w_ctrl_ok;
    logic [CARD_W-1:0]                      w_card_i;
    logic [CARD_W-1:0]                      w_card_j;

    assign w_lfsr_n = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

    // Smallest all-ones mask covering the current index keeps rejections below 50%.
    always_comb begin
        w_mask = 6'd1;
        if (r_idx >= 6'd32)
            w_mask = 6'd63;
        else if (r_idx >= 6'd16)
            w_mask = 6'd31;
        else if (r_idx >= 6'd8)
            w_mask = 6'd15;
        else if (r_idx >= 6'd4)
            w_mask = 6'd7;
        else if (r_idx >= 6'd2)
            w_mask = 6'd3;
    end

    assign w_j       = w_lfsr_n[5:0] & w_mask;
    assign w_accept  = (w_j <= r_idx);
    assign w_swap    = (r_state == ST_SHUFFLE) && w_accept;
    assign w_ctrl_ok = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_card_i  = r_deck[r_idx];
    assign w_card_j  = r_deck[w_j];

    generate
        for (genvar gi = 0; gi < NUM_CARDS; gi++) begin : g_slot
            localparam logic [3:0] RANK = 4'(gi % 13);
            localparam logic [1:0] SUIT = 2'(gi / 13);
            always_comb begin
                w_deck_next[gi] = r_deck[gi];
                if (r_state == ST_INIT)
                    w_deck_next[gi] = {RANK, SUIT, 1'b0};
                else if (w_swap && (r_idx == 6'(gi)))
                    w_deck_next[gi] = w_card_j;
                else if (w_swap && (w_j == 6'(gi)))
                    w_deck_next[gi] = w_card_i;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_deck <= '0;
        else
            r_deck <= w_deck_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lfsr  <= DEFAULT_SEED;
            r_idx   <= 6'd0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_idx   <= 6'(NUM_CARDS - 1);
                    r_state <= ST_SHUFFLE;
                end
                ST_SHUFFLE: begin
                    r_lfsr <= w_lfsr_n;
                    if (w_accept) begin
                        if (r_idx == 6'd1)
                            r_state <= ST_DONE;
                        else
                            r_idx <= r_idx - 6'd1;
                    end
                end
                default: begin
                    if (seed_load)
                        r_lfsr <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
                    if (start)
                        r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign busy  = (r_state == ST_INIT) || (r_state == ST_SHUFFLE);
    assign ready = (r_state == ST_DONE);
    assign deck  = r_deck;

    logic w_unused;
    assign w_unused = w_ctrl_ok;

endmodule

// File: tb/tb_deck_shuffler.sv
// Randomized bench for deck_shuffler against an array-based Fisher-Yates model.
// Prints one line per shuffle and a final pass/total summary.
module tb_deck_shuffler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  seed = 16'h0000;
    logic         seed_load = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic         ready;
    logic [363:0] deck;

    int           n_checks = 0;
    int           n_pass = 0;
    int           m_deck[52];
    int           m_cycles;
    logic [15:0]  m_lfsr;
    logic [15:0]  exp_lfsr;
    logic [363:0] first_deck;
    logic [363:0] saved_deck;

    deck_shuffler dut (
        .clk       (clk),
        .rst       (rst),
        .seed      (seed),
        .seed_load (seed_load),
        .start     (start),
        .busy      (busy),
        .ready     (ready),
        .deck      (deck)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [363:0] got, input logic [363:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference shuffle: plain arrays, mask grown until it covers i.
    task automatic model_shuffle(input logic [15:0] s);
        int          i;
        int          j;
        int          msk;
        int          t;
        bit          done;
        logic [15:0] x;
        x = (s == 16'h0000) ? 16'hACE1 : s;
        for (int k = 0; k < 52; k++)
            m_deck[k] = ((k % 13) << 3) | ((k / 13) << 1);
        i = 51;
        m_cycles = 0;
        done = 0;
        while (!done) begin
            x = lfsr_step(x);
            m_cycles++;
            msk = 1;
            while (msk < i)
                msk = msk * 2 + 1;
            j = int'(x[5:0]) & msk;
            if (j <= i) begin
                t = m_deck[i];
                m_deck[i] = m_deck[j];
                m_deck[j] = t;
                if (i == 1)
                    done = 1;
                else
                    i--;
            end
        end
        m_lfsr = x;
    endtask

    function automatic logic [363:0] model_vec();
        logic [363:0] v;
        v = '0;
        for (int k = 0; k < 52; k++)
            v[k*7 +: 7] = 7'(m_deck[k]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 3000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic do_start(input bit load, input logic [15:0] s);
        seed      = s;
        seed_load = load;
        start     = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
    endtask

    task automatic shuffle_check(input string tag, input bit load, input logic [15:0] s);
        int cnt;
        model_shuffle(load ? s : exp_lfsr);
        do_start(load, s);
        check_val({tag, "_busy"}, 364'(busy), 364'(1));
        check_val({tag, "_ready_low"}, 364'(ready), 364'(0));
        wait_ready(cnt);
        check_val({tag, "_cycles"}, 364'(cnt), 364'(1 + m_cycles));
        check_val({tag, "_deck"}, deck, model_vec());
        exp_lfsr = m_lfsr;
        $display("shuffle %s load=%0d seed=%h cycles=%0d", tag, load, s, cnt);
    endtask

    task automatic perm_check(input string tag);
        bit          seen[52];
        int          err;
        logic [6:0]  c;
        err = 0;
        for (int k = 0; k < 52; k++)
            seen[k] = 0;
        for (int k = 0; k < 52; k++) begin
            c = deck[k*7 +: 7];
            if (c[0])
                err++;
            if (c[6:3] > 4'd12)
                err++;
            else if (seen[int'(c[2:1]) * 13 + int'(c[6:3])])
                err++;
            else
                seen[int'(c[2:1]) * 13 + int'(c[6:3])] = 1;
        end
        check_val(tag, 364'(err), 364'(0));
    endtask

    initial begin
        int          cnt;
        logic [15:0] s;

        repeat (3) tick();
        check_val("rst_busy", 364'(busy), 364'(0));
        check_val("rst_ready", 364'(ready), 364'(0));
        check_val("rst_deck", deck, '0);
        rst = 1'b1;
        tick();
        exp_lfsr = 16'hACE1;

        shuffle_check("ace1", 0, 16'h0000);
        first_deck = deck;
        perm_check("ace1_perm");

        shuffle_check("seed0", 1, 16'h0000);
        check_val("seed0_eq_ace1", deck, first_deck);

        shuffle_check("s1234", 1, 16'h1234);
        saved_deck = deck;
        check_val("s1234_differs", 364'(deck != first_deck), 364'(1));
        shuffle_check("s1234_again", 1, 16'h1234);
        check_val("s1234_repeat", deck, saved_deck);

        // start and seed_load during SHUFFLE must be ignored
        s = 16'($urandom_range(1, 65535));
        model_shuffle(s);
        do_start(1, s);
        tick();
        repeat (10) tick();
        seed = 16'h5555;
        seed_load = 1'b1;
        start = 1'b1;
        tick();
        seed_load = 1'b0;
        start = 1'b0;
        check_val("intr_busy", 364'(busy), 364'(1));
        wait_ready(cnt);
        check_val("intr_cycles", 364'(12 + cnt), 364'(1 + m_cycles));
        check_val("intr_deck", deck, model_vec());
        perm_check("intr_perm");
        $display("shuffle intr seed=%h cycles=%0d", s, 12 + cnt);
        exp_lfsr = m_lfsr;
        shuffle_check("redo_from_done", 0, 16'h0000);

        // asynchronous reset partway through SHUFFLE
        do_start(0, 16'h0000);
        repeat (21) tick();
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_deck", deck, '0);
        check_val("mid_rst_busy", 364'(busy), 364'(0));
        check_val("mid_rst_ready", 364'(ready), 364'(0));
        tick();
        rst = 1'b1;
        tick();
        exp_lfsr = 16'hACE1;
        shuffle_check("after_rst", 0, 16'h0000);
        check_val("after_rst_eq_ace1", deck, first_deck);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        exp_lfsr = 16'hACE1;
        shuffle_check("s00ff_same_cycle", 1, 16'h00FF);

        for (int n = 0; n < 6; n++) begin
            shuffle_check("rand", 1'($urandom_range(0, 1)), 16'($urandom));
            perm_check("rand_perm");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
